seq_bit_serializer: RTL and testbench
=====================================

# seq_bit_serializer

Parallel-to-serial front end for the bitstream sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the serial `w` line consumed directly by the detector FSM. A one-entry holding register lets back-to-back words stream with no idle gap.

## Interface

Parameters:
- `WIDTH`, default 8: word width; legal range 2..32.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `w`  out  1  serial bit to the detector. Registered.
- `w_valid`  out  1  `w` carries a data bit this cycle. Registered.
- `word_done`  out  1  one-cycle pulse, coincident with the last bit of a word.
- `busy`  out  1  a word is shifting or held.

## Operation

- A word is accepted on any rising edge where `in_valid && in_ready` is true.
- `in_ready = !hold_full`. This is combinational from a register only; it has no path from `in_valid`.
- FSM states are ST_IDLE and ST_SHIFT.
- **ST_IDLE:**
  - `w_valid=0` and `w=0`.
  - An accepted word loads the shifter directly, resets the bit counter to 0, and moves the FSM to ST_SHIFT.
- **ST_SHIFT:**
  - Each cycle presents one bit and increments the counter.
  - An accepted word goes into the holding register and sets `hold_full`.
- **Last bit** (counter == WIDTH-1), priority order:
  - If `hold_full`: load the held word into the shifter, clear `hold_full`, counter to 0, stay in ST_SHIFT.
  - Else if a word is accepted this cycle: load it directly into the shifter, counter to 0, stay in ST_SHIFT.
  - Else: go to ST_IDLE.
- **Last bit while `hold_full` and `in_valid` are both high:** the word is not accepted, because `in_ready` was 0. It is accepted on the next cycle into the now-empty hold.
- **Bit order:** MSB_FIRST=1 sends `in_data[WIDTH-1]` down to `in_data[0]`; MSB_FIRST=0 sends the reverse.
- **Counter width** is `$clog2(WIDTH)`. It wraps only through an explicit reload to 0, never by overflow.
- **`busy`** = (state == ST_SHIFT) || `hold_full`.
- **Reset** (any time, including mid-word): discards the shifter and the hold, and forces ST_IDLE.
- **Values while `rst_n` is low:** `w=0`, `w_valid=0`, `word_done=0`, `busy=0`, `in_ready=1`, `hold_full=0`, counter=0.

## Timing

- **Latency:** a word accepted at edge E puts its first bit on `w` (with `w_valid=1`) in the cycle following E. Its last bit appears WIDTH-1 cycles after that.
- **Throughput:** one bit per clock. Continuous input yields a gapless `w_valid=1` stream of WIDTH bits per word.
- **`word_done`:** high exactly in the cycle carrying the final bit of each word. It is never asserted for a word discarded by reset.
- **`w` and `w_valid`:** change only on clock edges, or asynchronously to 0 on reset assertion.
- **Reset release:** the first acceptance is possible on the first rising edge after `rst_n` rises.

## Structure

- Shared package `seq_pkg` holds:
  - State encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1.
  - `SEQ_WORD_W` default (8), for reuse by the detector benches.
- Sub-module `seq_hold_reg` is a one-entry WIDTH-bit buffer.
  - Inputs: `load` and `take`.
  - Outputs: `full` and `data`.
  - It resets empty.
- The FSM, counter and shifter live in the top level.

## Test plan

- **Single word, MSB first:** reset, then one word 8'hB6 (1011_0110).
  - `w` = 1,0,1,1,0,1,1,0 on 8 consecutive cycles with `w_valid=1`.
  - `word_done` high on the 8th cycle only.
  - Then `w_valid=0`, `busy=0`.
- **LSB first:** MSB_FIRST=0, word 8'hB6.
  - `w` = 0,1,1,0,1,1,0,1.
- **Back-to-back:** `in_valid` held high with words 8'hB6, 8'h0F, 8'hF0.
  - 24 consecutive `w_valid=1` cycles, no gap.
  - `in_ready` low while the hold is full.
  - `word_done` pulses at bit cycles 8, 16 and 24.
- **Late arrival:** hold empty, next word presented exactly on the last-bit cycle.
  - Direct load; the next word's first bit follows with no gap.
- **Reset mid-word:** assert `rst_n=0` after 3 bits of 8'hB6, with a second word held.
  - `w`, `w_valid` and `busy` go to 0 immediately; `in_ready=1`.
  - After release, no residual bits are emitted.
- **Detector integration:** feed 8'b0101_1011 into `fsm_11_seqdetector`.
  - Detector `z` asserts after each pair of consecutive 1s in the `w` stream, at the cycle offsets the detector's own spec defines.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the bitstream front end and the sequence detector benches.
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int SEQ_WORD_W = 8;

endpackage

// File: rtl/seq_hold_reg.sv
// One-entry word buffer that lets the next word wait while the current one shifts out.
module seq_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  // A load wins over a take; the serializer never issues both in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= din;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out on w.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on the hold register, never on in_valid.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             accept;
  logic             last;
  logic             hold_load;
  logic             hold_take;

  assign in_ready  = !hold_full;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(WIDTH - 1));
  assign hold_load = accept && (state == ST_SHIFT) && !last;
  assign hold_take = (state == ST_SHIFT) && last && hold_full;

  // The outgoing bit always sits at the shifter's leading end; idle keeps the shifter cleared.
  assign shifted = MSB_FIRST ? (sh << 1) : (sh >> 1);
  assign w       = MSB_FIRST ? sh[WIDTH-1] : sh[0];
  assign w_valid = (state == ST_SHIFT);
  assign busy    = (state == ST_SHIFT) || hold_full;

  seq_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (hold_load),
    .take (hold_take),
    .din  (in_data),
    .full (hold_full),
    .data (hold_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sh        <= '0;
      word_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          word_done <= 1'b0;
          if (accept) begin
            sh    <= in_data;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last) begin
            word_done <= 1'b0;
            cnt       <= '0;
            if (hold_full) begin
              sh <= hold_data;
            end else if (accept) begin
              sh <= in_data;
            end else begin
              sh    <= '0;
              state <= ST_IDLE;
            end
          end else begin
            sh        <= shifted;
            cnt       <= cnt + 1'b1;
            // Registered so the pulse lines up with the bit the next cycle presents.
            word_done <= (cnt == CW'(WIDTH - 2));
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          sh        <= '0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers share one input stream.
module tb_seq_bit_serializer;

  localparam int W = seq_pkg::SEQ_WORD_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready_m, w_m, w_valid_m, word_done_m, busy_m;
  logic         in_ready_l, w_l, w_valid_l, word_done_l, busy_l;

  int errors = 0;
  int checks = 0;

  // Expected stream entries are {word_done, w}, one per output bit cycle.
  logic [1:0] exp_msb_q[$];
  logic [1:0] exp_lsb_q[$];

  int max_run = 0;
  int cur_run = 0;
  int done_cnt = 0;
  bit saw_not_ready = 0;

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .w(w_m), .w_valid(w_valid_m),
    .word_done(word_done_m), .busy(busy_m)
  );

  seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .w(w_l), .w_valid(w_valid_l),
    .word_done(word_done_l), .busy(busy_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted word becomes W consecutive output bits in spec bit order.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready_m) begin
      for (int i = 0; i < W; i++) begin
        exp_msb_q.push_back({(i == W - 1), in_data[W-1-i]});
        exp_lsb_q.push_back({(i == W - 1), in_data[i]});
      end
    end
  end

  // Monitor: pending bits must be on w now; more than one word pending means the hold is full.
  always @(negedge clk) begin
    logic [1:0] em, el;
    int         pend;
    pend = exp_msb_q.size();
    check("msb_w_valid", w_valid_m, pend > 0);
    check("lsb_w_valid", w_valid_l, pend > 0);
    check("msb_in_ready", in_ready_m, !(pend > W));
    check("lsb_in_ready", in_ready_l, !(pend > W));
    check("msb_busy", busy_m, pend > 0);
    check("lsb_busy", busy_l, pend > 0);
    if (pend > 0) begin
      em = exp_msb_q.pop_front();
      el = exp_lsb_q.pop_front();
    end else begin
      em = 2'b00;
      el = 2'b00;
    end
    check("msb_w", w_m, em[0]);
    check("lsb_w", w_l, el[0]);
    check("msb_word_done", word_done_m, em[1]);
    check("lsb_word_done", word_done_l, el[1]);
    if (w_valid_m) cur_run++;
    else cur_run = 0;
    if (cur_run > max_run) max_run = cur_run;
    if (word_done_m) done_cnt++;
    if (!in_ready_m) saw_not_ready = 1;
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds in_valid high until the word is taken; in_valid stays high for back-to-back callers.
  task automatic send(input logic [W-1:0] d);
    bit acc;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = in_ready_m;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    errors++;
    $display("FAIL send_timeout: word %0h not accepted within 100 cycles", d);
  endtask

  task automatic check_reset_outputs();
    check("rst_msb_w", w_m, 1'b0);
    check("rst_msb_w_valid", w_valid_m, 1'b0);
    check("rst_msb_busy", busy_m, 1'b0);
    check("rst_msb_in_ready", in_ready_m, 1'b1);
    check("rst_msb_word_done", word_done_m, 1'b0);
    check("rst_lsb_w", w_l, 1'b0);
    check("rst_lsb_w_valid", w_valid_l, 1'b0);
    check("rst_lsb_busy", busy_l, 1'b0);
    check("rst_lsb_in_ready", in_ready_l, 1'b1);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    exp_msb_q.delete();
    exp_lsb_q.delete();
    #1;
    check_reset_outputs();
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    release_reset();

    // Single word, both bit orders.
    send(8'hB6);
    idle(12);

    // Back-to-back: one gapless 24-bit run, hold full observed.
    max_run = 0;
    done_cnt = 0;
    saw_not_ready = 0;
    send(8'hB6);
    send(8'h0F);
    send(8'hF0);
    idle(30);
    check("b2b_max_run", max_run, 24);
    check("b2b_word_done_count", done_cnt, 3);
    check("b2b_saw_not_ready", saw_not_ready, 1'b1);

    // Late arrival: next word presented exactly on the last-bit cycle.
    max_run = 0;
    send(8'hB6);
    in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    send(8'h3C);
    idle(20);
    check("late_max_run", max_run, 16);

    // Reset mid-word with a second word held.
    send(8'hB6);
    send(8'h0F);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pre_reset_hold_full", in_ready_m, 1'b0);
    @(posedge clk);
    #2;
    assert_reset();
    release_reset();
    done_cnt = 0;
    idle(20);
    check("post_reset_no_word_done", done_cnt, 0);

    // Random words with random gaps.
    for (int n = 0; n < 40; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap);
      send(W'($urandom));
    end
    idle(30);
    check("drain_empty", exp_msb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
